// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared defaults and arithmetic helpers for the conv MAC pipeline.
package conv_mac_pkg;

  localparam int A_W_DEF       = 16;
  localparam int B_W_DEF       = 8;
  localparam int ACC_W_DEF     = 24;
  localparam int NUM_STAGE_DEF = 2;

  // Result of a saturating add: clamped value plus a flag set when clamping happened.
  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Signed add of two sign-extended operands, clamped to a w-bit signed range (w <= 62).
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w);
    sat_res_t           r;
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 32'd1));
    if (sum > max_v) begin
      r.val = max_v;
      r.ovf = 1'b1;
    end else if (sum < min_v) begin
      r.val = min_v;
      r.ovf = 1'b1;
    end else begin
      r.val = sum;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_mul_core.sv
// conv_mac_mul_core: signed A*B product followed by an enabled register chain
// that carries the product together with its valid/acc/last sideband.
module conv_mac_mul_core
  import conv_mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [A_W-1:0]    din0,
  input  logic signed [B_W-1:0]    din1,
  input  logic                     in_acc,
  input  logic                     in_last,
  output logic signed [A_W+B_W-1:0] prod,
  output logic                     valid,
  output logic                     acc,
  output logic                     last
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod_r  [NUM_STAGE];
  logic                  valid_r [NUM_STAGE];
  logic                  acc_r   [NUM_STAGE];
  logic                  last_r  [NUM_STAGE];

  // Product/sideband pipeline: every stage advances together on en, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_r[i]  <= {P_W{1'b0}};
        valid_r[i] <= 1'b0;
        acc_r[i]   <= 1'b0;
        last_r[i]  <= 1'b0;
      end
    end else if (en) begin
      prod_r[0]  <= din0 * din1;
      valid_r[0] <= in_valid;
      acc_r[0]   <= in_acc;
      last_r[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_r[i]  <= prod_r[i-1];
        valid_r[i] <= valid_r[i-1];
        acc_r[i]   <= acc_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  assign prod  = prod_r[NUM_STAGE-1];
  assign valid = valid_r[NUM_STAGE-1];
  assign acc   = acc_r[NUM_STAGE-1];
  assign last  = last_r[NUM_STAGE-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined signed multiply / multiply-accumulate with
// valid/ready flow control. Beats tagged in_acc are summed over a window and
// emitted on the window's last beat; untagged beats emit their product.
// Optional build macro SAT_EN: saturating accumulation with sticky out_ovf;
// without it the accumulator wraps and out_ovf stays 0.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  input  logic                    in_acc,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] dout,
  output logic                    out_ovf
);

  localparam int P_W = A_W + B_W;

  logic                    en_s;
  logic signed [P_W-1:0]   m_prod_s;
  logic                    m_valid_s;
  logic                    m_acc_s;
  logic                    m_last_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] sum_s;
  logic                    add_ovf_s;

  logic signed [ACC_W-1:0] acc_r;
  logic                    open_r;
  logic                    ovf_win_r;
  logic signed [ACC_W-1:0] dout_r;
  logic                    out_valid_r;
  logic                    out_ovf_r;

  // The whole pipe moves only when the output register is free or being drained.
  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s;

  conv_mac_mul_core #(
    .A_W       (A_W),
    .B_W       (B_W),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .en       (en_s),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .in_acc   (in_acc),
    .in_last  (in_last),
    .prod     (m_prod_s),
    .valid    (m_valid_s),
    .acc      (m_acc_s),
    .last     (m_last_s)
  );

  assign prod_ext_s = ACC_W'(m_prod_s);

`ifdef SAT_EN
  sat_res_t sat_s;

  // Window sum: a closed window restarts from zero; the add clamps to ACC_W.
  always_comb begin
    base_s    = open_r ? acc_r : {ACC_W{1'b0}};
    sat_s     = sat_add(64'(base_s), 64'(prod_ext_s), ACC_W);
    sum_s     = sat_s.val[ACC_W-1:0];
    add_ovf_s = sat_s.ovf;
  end
`else
  // Window sum: a closed window restarts from zero; the add wraps modulo 2^ACC_W.
  always_comb begin
    base_s    = open_r ? acc_r : {ACC_W{1'b0}};
    sum_s     = base_s + prod_ext_s;
    add_ovf_s = 1'b0;
  end
`endif

  // Accumulate/output stage: standalone beats bypass the window state entirely.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      open_r      <= 1'b0;
      ovf_win_r   <= 1'b0;
      dout_r      <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else if (en_s) begin
      if (m_valid_s && !m_acc_s) begin
        dout_r      <= prod_ext_s;
        out_valid_r <= 1'b1;
        out_ovf_r   <= 1'b0;
      end else if (m_valid_s && !m_last_s) begin
        acc_r       <= sum_s;
        open_r      <= 1'b1;
        ovf_win_r   <= (open_r && ovf_win_r) || add_ovf_s;
        out_valid_r <= 1'b0;
      end else if (m_valid_s) begin
        dout_r      <= sum_s;
        out_valid_r <= 1'b1;
        out_ovf_r   <= (open_r && ovf_win_r) || add_ovf_s;
        acc_r       <= {ACC_W{1'b0}};
        open_r      <= 1'b0;
        ovf_win_r   <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign dout      = dout_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe (default parameters): the driver pushes
// hand-computed results as beats are accepted, a negedge monitor pops and checks.
module tb_conv_mac_pipe;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] din0 = 16'sd0;
  logic signed [7:0]  din1 = 8'sd0;
  logic               in_acc = 1'b0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [23:0] dout;
  logic               out_ovf;

  conv_mac_pipe dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_ovf   (out_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic signed [23:0] d;
    logic               o;
    logic               chk_lat;
    int                 cyc;
  } exp_t;

  exp_t               sb[$];
  exp_t               e;
  int                 tests = 0;
  int                 fails = 0;
  int                 cyc = 0;
  logic               hold_chk = 1'b0;
  logic signed [23:0] hold_d;

  // cycle counter used for latency measurement
  always @(posedge ap_clk) cyc <= cyc + 1;

  // monitor: reset state, stall behaviour, and scoreboard comparison on handshake
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      tests++;
      if (out_valid !== 1'b0 || dout !== 24'sd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_state: valid=%b dout=%0d ovf=%b in_ready=%b, want 0/0/0/1",
                 out_valid, dout, out_ovf, in_ready);
      end
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        tests++;
        if (out_valid !== 1'b1 || dout !== hold_d) begin
          fails++;
          $display("FAIL stall_hold: valid=%b dout=%0d, want 1/%0d", out_valid, dout, hold_d);
        end
      end
      if (out_valid && !out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_in_ready: in_ready=%b, want 0", in_ready);
        end
        hold_chk = 1'b1;
        hold_d   = dout;
      end else begin
        hold_chk = 1'b0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: dout=%0d with no result pending", dout);
        end else begin
          e = sb.pop_front();
          if (dout !== e.d || out_ovf !== e.o) begin
            fails++;
            $display("FAIL result: dout=%0d ovf=%b, want %0d/%b", dout, out_ovf, e.d, e.o);
          end
          if (e.chk_lat) begin
            tests++;
            if (cyc - e.cyc != 3) begin
              fails++;
              $display("FAIL latency: got %0d cycles, want 3", cyc - e.cyc);
            end
          end
        end
      end
    end
  end

  // drive one beat; call just after a posedge; returns just after the accept edge
  task automatic send(input int a, input int b, input logic acc, input logic last,
                      input logic push, input int exp_d, input logic exp_o, input logic lat);
    exp_t x;
    bit   ok;
    din0     = 16'(a);
    din1     = 8'(b);
    in_acc   = acc;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%b, want 1 within 200 cycles", in_ready);
    end else if (push) begin
      x.d = 24'(exp_d);
      x.o = exp_o;
      x.chk_lat = lat;
      x.cyc = cyc;
      sb.push_back(x);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    bit seen;
    idle(3);
    ap_rst_n = 1'b1;
    idle(2);

    // standalone product with latency check
    send(1000, -3, 1'b0, 1'b0, 1'b1, -3000, 1'b0, 1'b1);
    idle(5);

    // four-beat window: 200 - 200 + 49 + 128
    send(100, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(-50, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(7, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(-1, -128, 1'b1, 1'b1, 1'b1, 177, 1'b0, 1'b0);
    idle(5);

    // single-beat window
    send(-9, 11, 1'b1, 1'b1, 1'b1, -99, 1'b0, 1'b0);
    idle(5);

    // backpressure: six standalone beats, 5-cycle stall after first output
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(i * 10, 3, 1'b0, 1'b0, 1'b1, i * 30, 1'b0, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge ap_clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          tests++;
          fails++;
          $display("FAIL bp_first_output: out_valid=%b, want 1 within 100 cycles", out_valid);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);

    // overflow window: 3 x (32767*127)
    send(32767, 127, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(32767, 127, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`ifdef SAT_EN
    send(32767, 127, 1'b1, 1'b1, 1'b1, 8388607, 1'b1, 1'b0);
`else
    send(32767, 127, 1'b1, 1'b1, 1'b1, -4292989, 1'b0, 1'b0);
`endif
    idle(5);

    // extremes: standalone most-negative product, then negative window
    send(-32768, -128, 1'b0, 1'b0, 1'b1, 4194304, 1'b0, 1'b0);
    send(-32768, 127, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(-32768, 127, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(-32768, 127, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`ifdef SAT_EN
    send(-32768, 127, 1'b1, 1'b1, 1'b1, -8388608, 1'b1, 1'b0);
`else
    send(-32768, 127, 1'b1, 1'b1, 1'b1, 131072, 1'b0, 1'b0);
`endif
    idle(5);

    // standalone beat in the middle of a window leaves the window intact
    send(3, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(2, -5, 1'b0, 1'b0, 1'b1, -10, 1'b0, 1'b0);
    send(4, 4, 1'b1, 1'b1, 1'b1, 25, 1'b0, 1'b0);
    idle(5);

    // reset mid-window discards the partial sum
    send(50, 50, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(60, 60, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    idle(1);
    ap_rst_n = 1'b1;
    idle(1);
    send(5, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(1, 1, 1'b1, 1'b1, 1'b1, 26, 1'b0, 1'b0);

    // drain the scoreboard
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge ap_clk);
    end
    idle(5);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
Parametrised pipelined signed multiply / multiply-accumulate unit for the conv datapath. It is the next generation of the fixed 16x8 combinational multiplier: operand widths, pipeline depth and accumulator width are configurable. It adds valid/ready flow control with backpressure and a per-beat accumulate mode that sums a kernel window and emits on the window's last beat. It sits between the line-buffer/weight fetch and the conv output writer.

Parameters:
A_W, 16, signed width of din0 (activation)
B_W, 8, signed width of din1 (weight)
ACC_W, 24, signed accumulator/output width; must be >= A_W+B_W
NUM_STAGE, 2, multiplier pipeline registers (>=1); total latency NUM_STAGE+1

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous reset, active low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
din0  in  A_W  signed operand A
din1  in  B_W  signed operand B
in_acc  in  1  1 = beat belongs to an accumulation window; 0 = standalone product
in_last  in  1  last beat of window (ignored when in_acc=0)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
dout  out  ACC_W  signed result
out_ovf  out  1  window/product overflowed ACC_W (SAT_EN only, else 0)

Behaviour:
- Clock/reset: single clock ap_clk; ap_rst_n asynchronous assert, active low, synchronous deassert by the system. Reset values: in_ready=1, out_valid=0, dout=0, out_ovf=0, all stage valids=0, accumulator=0, window-open flag=0.
- Global advance: en = !out_valid || out_ready. in_ready = en. All stages shift only when en=1; stalled stages hold data and sideband (valid, acc, last). No bubble collapsing.
- Multiplier: stage 1 registers the full-width signed product A*B (A_W+B_W bits). Stages 2..NUM_STAGE delay it along with valid/acc/last. The product is sign-extended to ACC_W.
- Accumulate stage (final register), for a valid beat entering when en=1:
  - acc=0: dout=product; out_valid=1; window state untouched (a standalone beat may appear mid-window).
  - acc=1, last=0: acc_reg = (window open ? acc_reg : 0) + product; window open=1; no output.
  - acc=1, last=1: dout = (window open ? acc_reg : 0) + product; out_valid=1; window open=0; acc_reg=0.
  - A single-beat window (first beat has last=1) emits its product.
- Latency: accepted beat to out_valid = NUM_STAGE+1 cycles when unstalled. Throughput is 1 beat/cycle.
- Overflow, default: addition wraps modulo 2^ACC_W.
- out_valid falls after an out_valid && out_ready handshake unless a new result is loaded in the same cycle.
- Reset mid-window: discards partial sum and in-flight beats; no output is produced for them.

Optional Feature:
SAT_EN:
- Defined: each accumulate add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A saturating add sets a sticky window overflow bit, presented on out_ovf with the emitting beat and cleared after the emit. A standalone beat gives out_ovf=0.
- Undefined: wrap arithmetic; out_ovf tied 0.

Decomposition:
- Package conv_mac_pkg: default width constants (A_W/B_W/ACC_W), NUM_STAGE default, and a saturating signed add function parametrised by width.
- One sub-module, conv_mac_mul_core: signed multiplier with an NUM_STAGE-deep enabled register chain carrying valid/acc/last. The accumulate stage and handshake stay in the top.

Test Plan:
- Standalone, defaults: din0=1000, din1=-3, in_acc=0, out_ready=1 -> dout=-3000 (24'hFFF448) exactly 3 cycles after accept.
- Window of 4: (100,2),(-50,4),(7,7),(-1,-128) with last on the 4th beat -> one output, dout=177; no out_valid for beats 1-3.
- Backpressure: stream 6 standalone beats with out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 while stalled, dout held stable. All 6 results delivered in order, none lost or duplicated.
- Overflow: 3 beats of (32767,127) in a window, ACC_W=24 -> SAT_EN: dout=8388607, out_ovf=1. No SAT_EN: dout=-4292989, out_ovf=0.
- Extremes: standalone (-32768,-128) -> dout=4194304. Window sum of 4 x (-32768,127) with SAT_EN -> -8388608, out_ovf=1.
- Reset mid-window: 2 beats accumulated, pulse ap_rst_n low 1 cycle, then a new window (5,5),(1,1)last -> dout=26. Outputs hold reset values during reset; no stale output.
